// File: rtl/if_stage_fetch.sv
// ============================================================================
// Module   : if_stage_fetch
// Brief    : Instruction-fetch stage with IF/ID pipeline register and debug counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shouldStall,
    input  logic        shouldJumpOrBranch,
    input  logic [31:0] jumpOrBranchPc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_4,
    output logic [31:0] instruction,
    output logic        id_valid,
    output logic [31:0] pc,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    // Word alignment is enforced on every path that loads the PC.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] PC_STEP          = 32'd4;

    logic [31:0] pc_q,           pc_d;
    logic [31:0] instruction_q,  instruction_d;
    logic [31:0] pc_4_q,         pc_4_d;
    logic        id_valid_q,     id_valid_d;
    logic [31:0] fetch_count_q,  fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    assign pc_plus4    = pc_q + PC_STEP;
    assign redirect_pc = {jumpOrBranchPc[31:2], 2'b00};

    // Stall outranks redirect: ID re-asserts the redirect once its operands settle.
    always_comb begin
        pc_d           = pc_q;
        instruction_d  = instruction_q;
        pc_4_d         = pc_4_q;
        id_valid_d     = id_valid_q;
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;

        if (shouldStall) begin
            pc_d = pc_q;
        end else if (shouldJumpOrBranch) begin
            pc_d           = redirect_pc;
            instruction_d  = NOP_INSTR;
            pc_4_d         = 32'd0;
            id_valid_d     = 1'b0;
            bubble_count_d = bubble_count_q + 32'd1;
        end else if (!imem_ready) begin
            instruction_d  = NOP_INSTR;
            pc_4_d         = 32'd0;
            id_valid_d     = 1'b0;
            bubble_count_d = bubble_count_q + 32'd1;
        end else begin
            pc_d          = pc_plus4;
            instruction_d = imem_rdata;
            pc_4_d        = pc_plus4;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_PC_ALIGNED;
            instruction_q  <= NOP_INSTR;
            pc_4_q         <= 32'd0;
            id_valid_q     <= 1'b0;
            fetch_count_q  <= 32'd0;
            bubble_count_q <= 32'd0;
        end else begin
            pc_q           <= pc_d;
            instruction_q  <= instruction_d;
            pc_4_q         <= pc_4_d;
            id_valid_q     <= id_valid_d;
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instruction  = instruction_q;
    assign pc_4         = pc_4_q;
    assign id_valid     = id_valid_q;
    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage_fetch.sv
// ============================================================================
// Module   : tb_if_stage_fetch
// Brief    : Directed plus randomized bench for if_stage_fetch against a cycle model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage_fetch;

    logic        clk;
    logic        rst;
    logic        shouldStall;
    logic        shouldJumpOrBranch;
    logic [31:0] jumpOrBranchPc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_4;
    logic [31:0] instruction;
    logic        id_valid;
    logic [31:0] pc;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: what ID should see after each edge.
    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
    logic        m_valid;

    if_stage_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .shouldStall        (shouldStall),
        .shouldJumpOrBranch (shouldJumpOrBranch),
        .jumpOrBranchPc     (jumpOrBranchPc),
        .imem_addr          (imem_addr),
        .imem_rdata         (imem_rdata),
        .imem_ready         (imem_ready),
        .pc_4               (pc_4),
        .instruction        (instruction),
        .id_valid           (id_valid),
        .pc                 (pc),
        .fetch_count        (fetch_count),
        .bubble_count       (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_fc    = 32'h0;
        m_bc    = 32'h0;
    endtask

    task automatic check_all(input string tag);
        check({tag, " pc"},        pc,           m_pc);
        check({tag, " imem_addr"}, imem_addr,    m_pc);
        check({tag, " instr"},     instruction,  m_instr);
        check({tag, " pc_4"},      pc_4,         m_pc4);
        check({tag, " id_valid"},  {31'd0, id_valid}, {31'd0, m_valid});
        check({tag, " fetch_cnt"}, fetch_count,  m_fc);
        check({tag, " bubble_cnt"},bubble_count, m_bc);
    endtask

    // Drive one cycle of inputs, advance one edge, apply the fetch rules to the model.
    task automatic step(input string tag, input logic stall, input logic jb,
                        input logic [31:0] tgt, input logic rdy, input logic [31:0] rdata);
        shouldStall        = stall;
        shouldJumpOrBranch = jb;
        jumpOrBranchPc     = tgt;
        imem_ready         = rdy;
        imem_rdata         = rdata;
        #1;
        check({tag, " addr_pre"}, imem_addr, m_pc);
        @(posedge clk);
        if (stall) begin
            // nothing moves
        end else if (jb) begin
            m_pc    = tgt & ~32'd3;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_bc    = m_bc + 1;
        end else if (!rdy) begin
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_bc    = m_bc + 1;
        end else begin
            m_instr = rdata;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fc    = m_fc + 1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] snap_instr, snap_bc;
        rst = 1'b1;
        shouldStall = 1'b0;
        shouldJumpOrBranch = 1'b0;
        jumpOrBranchPc = 32'h0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        model_reset();

        // T1: reset values, then first fetch
        #2;
        check_all("T1_reset");
        #1 rst = 1'b0;
        step("T1_fetch", 0, 0, 32'h0, 1, 32'h2008_0005);
        check("T1 instr const", instruction, 32'h2008_0005);
        check("T1 pc_4 const",  pc_4, 32'h4);
        check("T1 pc const",    pc, 32'h4);
        check("T1 fc const",    fetch_count, 32'd1);
        step("T1_fetch2", 0, 0, 32'h0, 1, 32'h1111_2222);

        // T2: stall at pc=8 for two edges
        snap_instr = instruction;
        step("T2_stall1", 1, 0, 32'h0, 1, 32'hDEAD_0001);
        step("T2_stall2", 1, 0, 32'h0, 0, 32'hDEAD_0002);
        check("T2 pc held", pc, 32'h8);
        check("T2 instr held", instruction, snap_instr);
        step("T2_release", 0, 0, 32'h0, 1, 32'h3333_4444);
        check("T2 pc next", pc, 32'hC);

        // T3: taken branch, then fetch from target
        snap_bc = bubble_count;
        step("T3_branch", 0, 1, 32'h40, 1, 32'hBAD0_BAD0);
        check("T3 pc", pc, 32'h40);
        check("T3 valid", {31'd0, id_valid}, 32'd0);
        check("T3 bubble", bubble_count, snap_bc + 32'd1);
        step("T3_fetch", 0, 0, 32'h0, 1, 32'h5555_6666);
        check("T3 pc_4", pc_4, 32'h44);

        // T4: stall and branch together: branch ignored
        step("T4_both", 1, 1, 32'h80, 1, 32'h7777_8888);
        check("T4 pc", pc, 32'h44);

        // T5: memory wait at 0x20, then redirect during wait
        step("T5_goto20", 0, 1, 32'h20, 1, 32'h0);
        snap_bc = bubble_count;
        for (int i = 0; i < 3; i++) step("T5_wait", 0, 0, 32'h0, 0, 32'h9999_0000);
        check("T5 pc", pc, 32'h20);
        check("T5 bubbles", bubble_count, snap_bc + 32'd3);
        step("T5_br_wait", 0, 1, 32'h60, 0, 32'h0);
        check("T5 redirect", pc, 32'h60);

        // T6: wrap, unaligned target, async reset without an edge
        step("T6_gotoTop", 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
        step("T6_wrap", 0, 0, 32'h0, 1, 32'hABCD_EF01);
        check("T6 wrap pc", pc, 32'h0);
        check("T6 wrap pc_4", pc_4, 32'h0);
        step("T6_unaligned", 0, 1, 32'h43, 1, 32'h0);
        check("T6 align", pc, 32'h40);
        step("T6_fetch", 0, 0, 32'h0, 1, 32'h0BAD_F00D);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("T6_async_rst");
        #2 rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic        r_st, r_jb, r_rd;
            logic [31:0] r_tgt, r_dat;
            r_st  = ($urandom_range(0, 99) < 20);
            r_jb  = ($urandom_range(0, 99) < 15);
            r_rd  = ($urandom_range(0, 99) < 75);
            r_tgt = $urandom;
            r_dat = $urandom;
            step("RND", r_st, r_jb, r_tgt, r_rd, r_dat);
        end

        // Asynchronous reset in the middle of random traffic
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("RND_async_rst");
        #2 rst = 1'b0;
        step("RND_after_rst", 0, 0, 32'h0, 1, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
